// File: rtl/key_cond_pkg.sv
// Shared types and sizing helpers for the push-button conditioner.
package key_cond_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } key_state_e;

  localparam int DEBOUNCE_MAX = (1 << 20) - 1;

  // Width that holds the largest of the three cycle counts without wrapping.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// One push-button channel: 2-flop synchronizer, debounce FSM, registered pulses.
// Auto-repeat while held is built only when KEY_CONDITIONER_REPEAT_EN is defined.
//
// state            | meaning
// ST_IDLE          | released, waiting for a low sample
// ST_PRESS_WAIT    | low seen, counting stable-low cycles
// ST_HELD          | debounced pressed (repeat timer runs here when enabled)
// ST_RELEASE_WAIT  | high seen while held, counting stable-high cycles
module key_debounce_channel
  import key_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n_i,
  output logic press_o,
  output logic release_o,
  output logic held_o
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  key_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          held_q, held_d;
  logic          key_low;

`ifdef KEY_CONDITIONER_REPEAT_EN
  localparam logic [CW-1:0] RPT_FIRST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RPT_NEXT  = CW'(REPEAT_PERIOD - 1);
  logic [CW-1:0] rpt_q, rpt_d;
  logic          rpt_armed_q, rpt_armed_d;
`endif

  assign key_low = ~sync_q[1];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    held_d    = held_q;
`ifdef KEY_CONDITIONER_REPEAT_EN
    rpt_d       = rpt_q;
    rpt_armed_d = rpt_armed_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (key_low) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!key_low) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = ST_HELD;
          cnt_d   = '0;
          press_d = 1'b1;
          held_d  = 1'b1;
`ifdef KEY_CONDITIONER_REPEAT_EN
          rpt_d       = '0;
          rpt_armed_d = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_HELD: begin
        if (!key_low) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = '0;
        end
`ifdef KEY_CONDITIONER_REPEAT_EN
        // Repeat timer freezes in RELEASE_WAIT so a bounce does not restart it.
        else if ((!rpt_armed_q && rpt_q == RPT_FIRST) || (rpt_armed_q && rpt_q == RPT_NEXT)) begin
          press_d     = 1'b1;
          rpt_d       = '0;
          rpt_armed_d = 1'b1;
        end else begin
          rpt_d = rpt_q + CW'(1);
        end
`endif
      end
      ST_RELEASE_WAIT: begin
        if (key_low) begin
          state_d = ST_HELD;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
          held_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        held_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= 2'b11;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], key_n_i};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      held_q    <= held_d;
    end
  end

`ifdef KEY_CONDITIONER_REPEAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_q       <= '0;
      rpt_armed_q <= 1'b0;
    end else begin
      rpt_q       <= rpt_d;
      rpt_armed_q <= rpt_armed_d;
    end
  end
`endif

  assign press_o   = press_q;
  assign release_o = release_q;
  assign held_o    = held_q;

endmodule

// File: rtl/key_conditioner.sv
// N_KEYS independent debounced push-button channels plus a combined event flag.
// Define KEY_CONDITIONER_REPEAT_EN to add auto-repeat press pulses while held.
module key_conditioner
  import key_cond_pkg::*;
#(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] held,
  output logic              any_event
);

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    key_debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .key_n_i  (key_n[g]),
      .press_o  (press_pulse[g]),
      .release_o(release_pulse[g]),
      .held_o   (held[g])
    );
  end

  // Inputs are all flop outputs, so this stays aligned with the pulses.
  assign any_event = |{press_pulse, release_pulse};

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
module tb_key_conditioner;

  logic       clk;
  logic       rst_n;
  logic [3:0] key_n;
  logic [3:0] press_pulse;
  logic [3:0] release_pulse;
  logic [3:0] held;
  logic       any_event;

  int n_checks;
  int n_fail;

  key_conditioner #(
    .N_KEYS         (4),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_n        (key_n),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .held         (held),
    .any_event    (any_event)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one active edge and return at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    bit rpt_exp;
    n_checks = 0;
    n_fail   = 0;
    key_n    = 4'hF;
    rst_n    = 1'b0;
    #1;
    check_val("rst_held", held, 4'h0);
    check_val("rst_press", press_pulse, 4'h0);
    check_val("rst_release", release_pulse, 4'h0);
    check_val("rst_any", any_event, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) step();

    // Key 0 pressed and stable: pulse at edge 6, held from edge 6.
    key_n[0] = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      step();
      check_val($sformatf("k0_press_e%0d", k), press_pulse[0], k == 6);
      check_val($sformatf("k0_held_e%0d", k), held[0], k >= 6);
      check_val($sformatf("k0_any_e%0d", k), any_event, k == 6);
    end

    // Key 1 short glitch low: nothing happens.
    key_n[1] = 1'b0;
    repeat (3) step();
    key_n[1] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      check_val("k1_glitch_press", press_pulse[1], 1'b0);
      check_val("k1_glitch_held", held[1], 1'b0);
    end

    // Key 0 released with a 2-cycle bounce, then released for good.
    key_n[0] = 1'b1;
    repeat (2) step();
    key_n[0] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      check_val("k0_bounce_release", release_pulse[0], 1'b0);
      check_val("k0_bounce_held", held[0], 1'b1);
    end
    key_n[0] = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      step();
      check_val($sformatf("k0_rel_e%0d", k), release_pulse[0], k == 6);
      check_val($sformatf("k0_rel_held_e%0d", k), held[0], k < 6);
      check_val($sformatf("k0_rel_nopress_e%0d", k), press_pulse[0], 1'b0);
    end
    repeat (4) step();

    // All keys together, then keep holding to observe auto-repeat on key 0.
    key_n = 4'h0;
    for (int k = 0; k <= 8; k++) begin
      step();
      check_val($sformatf("all_press_e%0d", k), press_pulse, (k == 6) ? 4'hF : 4'h0);
      check_val($sformatf("all_any_e%0d", k), any_event, k == 6);
    end
    for (int j = 3; j <= 30; j++) begin
      step();
`ifdef KEY_CONDITIONER_REPEAT_EN
      rpt_exp = (j >= 10) && ((j - 10) % 3 == 0);
`else
      rpt_exp = 1'b0;
`endif
      check_val($sformatf("rpt_k0_p%0d", j), press_pulse[0], rpt_exp);
      check_val($sformatf("rpt_held_p%0d", j), held, 4'hF);
    end

    // Reset while all keys held: outputs drop at once, no release pulse.
    #2;
    rst_n = 1'b0;
    #1;
    check_val("midrst_held", held, 4'h0);
    check_val("midrst_release", release_pulse, 4'h0);
    check_val("midrst_press", press_pulse, 4'h0);
    check_val("midrst_any", any_event, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      step();
      check_val($sformatf("postrst_k2_press_e%0d", k), press_pulse[2], k == 6);
      check_val($sformatf("postrst_k2_held_e%0d", k), held[2], k >= 6);
      check_val($sformatf("postrst_release_e%0d", k), release_pulse, 4'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
